dcm_lock_mon: RTL and testbench
===============================

Name: dcm_lock_mon

Overview:
- Consumer side of the DCM reset path: watches the DCM after dcm_rst is released and decides when the system domain may leave reset.
- Detects a stopped DCM input clock (clkin_stop) from a toggle generated in the clkin domain.
- Qualifies locked for a stable period, holds sys_rst until then, and counts lock-loss events.
- clkin_stop feeds back to the DCM reset generator; sys_rst/lock_ok feed downstream logic.

Parameters:
- STOP_TO, 64: clk cycles with no clkin toggle edge before clkin_stop asserts (>=2).
- LOCK_STABLE, 256: consecutive synchronized-locked cycles required before sys_rst release (>=2).
- TW, 10: width of the stop and stable timers; must satisfy 2^TW > max(STOP_TO, LOCK_STABLE).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dcm_rst  in  1  DCM reset from the DCM reset generator, synchronous to clk
- locked  in  1  DCM locked, asynchronous
- clkin_tgl  in  1  toggles once per clkin divided period, asynchronous
- clkin_stop  out  1  DCM input clock stopped, registered
- sys_rst  out  1  system reset, active-high, registered
- lock_ok  out  1  lock qualified, registered, always equals ~sys_rst
- relock_cnt  out  8  saturating count of RUN->lock-loss events

Behaviour:
- Reset values: clkin_stop=0, sys_rst=1, lock_ok=0, relock_cnt=0. All sync flops clear to 0, timers clear to 0, state=RST_WAIT.
- Synchronizers:
  - locked passes through 2 flops to give locked_s.
  - clkin_tgl passes through 3 flops (t1, t2, t3); edge = t2^t3.
- Stop timer (stop_cnt, TW bits):
  - edge=1: stop_cnt <= 0.
  - Otherwise, if stop_cnt < STOP_TO: stop_cnt increments.
  - The counter saturates and never wraps.
- clkin_stop register:
  - Set when ~edge and stop_cnt==STOP_TO-1.
  - Cleared on any cycle with edge=1; otherwise holds.
  - It therefore rises exactly STOP_TO cycles after the last edge cycle, and falls the cycle after the next edge.
- Lock FSM states: RST_WAIT, LOCK_WAIT, STABLE, RUN.
  - Priority override in every state: if dcm_rst=1 or clkin_stop=1, next state is RST_WAIT and the stable timer is cleared.
  - RST_WAIT: if dcm_rst=0 and clkin_stop=0, go to LOCK_WAIT.
  - LOCK_WAIT: if locked_s=1, go to STABLE with stab_cnt <= 0.
  - STABLE: if locked_s=0, go to LOCK_WAIT. Else if stab_cnt==LOCK_STABLE-1, go to RUN. Else stab_cnt increments.
  - RUN: if locked_s=0, go to LOCK_WAIT and relock_cnt increments, saturating at 255. Otherwise stay in RUN.
- relock_cnt does not increment when RUN is left via the dcm_rst/clkin_stop override.
- sys_rst <= (next_state != RUN); lock_ok <= (next_state == RUN). Both change on the same edge as the state register.
- Latency, with dcm_rst=0, clkin running and state=LOCK_WAIT: locked is first sampled high at edge n, and sys_rst falls at edge n+LOCK_STABLE+2.
- Latency on lock loss from RUN: locked sampled low at edge n gives sys_rst=1 at edge n+2.
- A locked glitch shorter than LOCK_STABLE cycles during STABLE restarts qualification from zero.
- rst mid-operation returns everything to reset values on the next edge, regardless of state or inputs.
- relock_cnt is cleared only by rst.

Test Plan:
- Setup for all scenarios: STOP_TO=8, LOCK_STABLE=16, clkin_tgl toggling every 4 clk.
- Normal lock: rst then dcm_rst=0, locked=1 from edge 10 -> sys_rst=1 through edge 27, sys_rst=0 and lock_ok=1 at edge 28; relock_cnt=0.
- Glitchy qualification: locked high 10 cycles, low 3 cycles, then high -> no release during the first window; release occurs LOCK_STABLE+2 edges after the second rise.
- Clock stop: in RUN, freeze clkin_tgl -> clkin_stop=1 exactly 8 cycles after the last edge and sys_rst=1 the following edge; relock_cnt unchanged. Resume toggling -> clkin_stop clears one cycle after the first edge, then the full requalification is required.
- Lock loss counting: 3 RUN->locked-low events -> relock_cnt=3. Force 300 events -> relock_cnt holds at 255.
- dcm_rst override: assert dcm_rst for 1 cycle in STABLE with stab_cnt=12 -> state RST_WAIT; after release, a full 16-cycle count is required.
- Reset mid-RUN: pulse rst with relock_cnt=5 and clkin_stop=0 -> next edge sys_rst=1, lock_ok=0, relock_cnt=0, clkin_stop=0.

Source files
------------

// File: rtl/dcm_lock_mon_if.sv
// Signal bundle between the DCM reset generator / DCM and the lock monitor.
// master drives the DCM-side inputs, slave is the monitor itself.
interface dcm_lock_mon_if;
  logic       dcm_rst;
  logic       locked;
  logic       clkin_tgl;
  logic       clkin_stop;
  logic       sys_rst;
  logic       lock_ok;
  logic [7:0] relock_cnt;

  modport master (
    output dcm_rst,
    output locked,
    output clkin_tgl,
    input  clkin_stop,
    input  sys_rst,
    input  lock_ok,
    input  relock_cnt
  );

  modport slave (
    input  dcm_rst,
    input  locked,
    input  clkin_tgl,
    output clkin_stop,
    output sys_rst,
    output lock_ok,
    output relock_cnt
  );
endinterface

// File: rtl/dcm_lock_mon.sv
// DCM lock monitor: detects a stopped input clock, qualifies locked for a stable
// period before releasing sys_rst, and counts lock losses seen while running.
module dcm_lock_mon #(
  parameter int unsigned STOP_TO     = 64,
  parameter int unsigned LOCK_STABLE = 256,
  parameter int unsigned TW          = 10
) (
  input  logic           clk,
  input  logic           rst,
  dcm_lock_mon_if.slave  bus
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    RST_WAIT  = 2'd0,
    LOCK_WAIT = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;

  logic            locked_s1;
  logic            locked_s;
  logic            tgl_t1;
  logic            tgl_t2;
  logic            tgl_t3;
  logic            tgl_edge;

  logic [TW-1:0]   stop_cnt;
  logic [TW-1:0]   stab_cnt;
  logic [TW-1:0]   stab_cnt_nxt;
  logic            relock_inc;

  logic            clkin_stop_q;
  logic            sys_rst_q;
  logic            lock_ok_q;
  logic [CW-1:0]   relock_cnt_q;

  // Synchronizers for the asynchronous locked level and clkin toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_s1 <= 1'b0;
      locked_s  <= 1'b0;
      tgl_t1    <= 1'b0;
      tgl_t2    <= 1'b0;
      tgl_t3    <= 1'b0;
    end else begin
      locked_s1 <= bus.locked;
      locked_s  <= locked_s1;
      tgl_t1    <= bus.clkin_tgl;
      tgl_t2    <= tgl_t1;
      tgl_t3    <= tgl_t2;
    end
  end

  assign tgl_edge = tgl_t2 ^ tgl_t3;

  // Stop timer saturates at STOP_TO; the flag rises as it crosses STOP_TO-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_cnt     <= '0;
      clkin_stop_q <= 1'b0;
    end else if (tgl_edge) begin
      stop_cnt     <= '0;
      clkin_stop_q <= 1'b0;
    end else begin
      if (stop_cnt < TW'(STOP_TO)) begin
        stop_cnt <= stop_cnt + TW'(1);
      end
      if (stop_cnt == TW'(STOP_TO - 1)) begin
        clkin_stop_q <= 1'b1;
      end
    end
  end

  // Lock FSM: state register and outputs follow next_state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RST_WAIT;
      stab_cnt     <= '0;
      sys_rst_q    <= 1'b1;
      lock_ok_q    <= 1'b0;
      relock_cnt_q <= '0;
    end else begin
      state     <= next_state;
      stab_cnt  <= stab_cnt_nxt;
      sys_rst_q <= (next_state != RUN);
      lock_ok_q <= (next_state == RUN);
      if (relock_inc && (relock_cnt_q != {CW{1'b1}})) begin
        relock_cnt_q <= relock_cnt_q + CW'(1);
      end
    end
  end

  // DCM reset or a stopped input clock overrides every state.
  always_comb begin
    next_state   = state;
    stab_cnt_nxt = stab_cnt;
    relock_inc   = 1'b0;
    if (bus.dcm_rst || clkin_stop_q) begin
      next_state   = RST_WAIT;
      stab_cnt_nxt = '0;
    end else begin
      case (state)
        RST_WAIT: begin
          next_state = LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (locked_s) begin
            next_state   = STABLE;
            stab_cnt_nxt = '0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            next_state = LOCK_WAIT;
          end else if (stab_cnt == TW'(LOCK_STABLE - 1)) begin
            next_state = RUN;
          end else begin
            stab_cnt_nxt = stab_cnt + TW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            next_state = LOCK_WAIT;
            relock_inc = 1'b1;
          end
        end
        default: begin
          next_state = RST_WAIT;
        end
      endcase
    end
  end

  assign bus.clkin_stop = clkin_stop_q;
  assign bus.sys_rst    = sys_rst_q;
  assign bus.lock_ok    = lock_ok_q;
  assign bus.relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_dcm_lock_mon.sv
// Directed bench for dcm_lock_mon with STOP_TO=8, LOCK_STABLE=16 and clkin_tgl
// toggling every 4 clk; expected edges are derived from the sync/FSM latencies.
module tb_dcm_lock_mon;

  localparam int unsigned STOP_TO     = 8;
  localparam int unsigned LOCK_STABLE = 16;
  localparam int unsigned TW          = 10;

  logic clk;
  logic rst;
  int   checks       = 0;
  int   failures     = 0;
  int   cyc          = 0;
  bit   tgl_run      = 1'b1;
  int   last_tgl_cyc = 0;

  dcm_lock_mon_if bus ();

  dcm_lock_mon #(
    .STOP_TO    (STOP_TO),
    .LOCK_STABLE(LOCK_STABLE),
    .TW         (TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // clkin divided toggle; updated at #2 so test code at #1 can gate it cleanly.
  initial begin
    bus.clkin_tgl = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tgl_run && (cyc % 4 == 0)) begin
        bus.clkin_tgl = ~bus.clkin_tgl;
        last_tgl_cyc  = cyc;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel 0 watches lock_ok, sel 1 watches clkin_stop.
  task automatic wait_sig(input int sel, input logic val, input int budget,
                          output bit ok, output int at_cyc);
    logic v;
    ok     = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      v = (sel == 0) ? bus.lock_ok : bus.clkin_stop;
      if (v === val) begin
        ok     = 1'b1;
        at_cyc = cyc;
        break;
      end
      step(1);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.dcm_rst = 1'b1;
    bus.locked  = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic loss_event(output bit ok);
    int at;
    bus.locked = 1'b0;
    step(3);
    bus.locked = 1'b1;
    wait_sig(0, 1'b1, 40, ok, at);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.dcm_rst = 1'b1;
    bus.locked  = 1'b0;
    step(2);
    checks++;
    if (bus.sys_rst !== 1'b1) begin failures++; $display("FAIL reset_sys_rst: got %b expected 1", bus.sys_rst); end
    checks++;
    if (bus.lock_ok !== 1'b0) begin failures++; $display("FAIL reset_lock_ok: got %b expected 0", bus.lock_ok); end
    checks++;
    if (bus.relock_cnt !== 8'd0) begin failures++; $display("FAIL reset_relock_cnt: got %0d expected 0", bus.relock_cnt); end
    checks++;
    if (bus.clkin_stop !== 1'b0) begin failures++; $display("FAIL reset_clkin_stop: got %b expected 0", bus.clkin_stop); end
    rst = 1'b0;
    step(3);
    checks++;
    if (bus.sys_rst !== 1'b1) begin failures++; $display("FAIL dcm_rst_hold: got %b expected 1", bus.sys_rst); end
  endtask

  task automatic test_normal_lock();
    bus.dcm_rst = 1'b0;
    step(9);
    bus.locked = 1'b1;
    step(18);
    checks++;
    if (bus.sys_rst !== 1'b1) begin failures++; $display("FAIL normal_sys_rst_e27: got %b expected 1", bus.sys_rst); end
    step(1);
    checks++;
    if (bus.sys_rst !== 1'b0) begin failures++; $display("FAIL normal_sys_rst_e28: got %b expected 0", bus.sys_rst); end
    checks++;
    if (bus.lock_ok !== 1'b1) begin failures++; $display("FAIL normal_lock_ok_e28: got %b expected 1", bus.lock_ok); end
    checks++;
    if (bus.relock_cnt !== 8'd0) begin failures++; $display("FAIL normal_relock_cnt: got %0d expected 0", bus.relock_cnt); end
  endtask

  task automatic test_glitch();
    bit early;
    do_reset();
    bus.dcm_rst = 1'b0;
    step(1);
    early      = 1'b0;
    bus.locked = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); if (bus.lock_ok !== 1'b0) early = 1'b1; end
    bus.locked = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); if (bus.lock_ok !== 1'b0) early = 1'b1; end
    bus.locked = 1'b1;
    for (int i = 0; i < 18; i++) begin step(1); if (bus.lock_ok !== 1'b0) early = 1'b1; end
    checks++;
    if (early !== 1'b0) begin failures++; $display("FAIL glitch_no_early_release: got %b expected 0", early); end
    step(1);
    checks++;
    if (bus.lock_ok !== 1'b1) begin failures++; $display("FAIL glitch_release: got %b expected 1", bus.lock_ok); end
  endtask

  task automatic test_clock_stop();
    bit   ok;
    int   at;
    int   exp;
    int   clr;
    logic [7:0] saved;
    saved   = bus.relock_cnt;
    tgl_run = 1'b0;
    exp     = last_tgl_cyc + 11;
    wait_sig(1, 1'b1, 40, ok, at);
    checks++;
    if (!ok || at != exp) begin failures++; $display("FAIL stop_rise_cycle: got %0d expected %0d", at, exp); end
    checks++;
    if (bus.sys_rst !== 1'b0) begin failures++; $display("FAIL stop_sys_rst_same_edge: got %b expected 0", bus.sys_rst); end
    step(1);
    checks++;
    if (bus.sys_rst !== 1'b1 || bus.lock_ok !== 1'b0) begin
      failures++; $display("FAIL stop_sys_rst_next: got %b/%b expected 1/0", bus.sys_rst, bus.lock_ok);
    end
    checks++;
    if (bus.relock_cnt !== saved) begin failures++; $display("FAIL stop_relock_cnt: got %0d expected %0d", bus.relock_cnt, saved); end
    step(5);
    tgl_run = 1'b1;
    wait_sig(1, 1'b0, 40, ok, clr);
    exp = last_tgl_cyc + 3;
    checks++;
    if (!ok || clr != exp) begin failures++; $display("FAIL stop_clear_cycle: got %0d expected %0d", clr, exp); end
    wait_sig(0, 1'b1, 60, ok, at);
    checks++;
    if (!ok || at != clr + 18) begin failures++; $display("FAIL stop_requal_cycle: got %0d expected %0d", at, clr + 18); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    bit all_ok;
    int at;
    bus.locked = 1'b0;
    step(2);
    checks++;
    if (bus.sys_rst !== 1'b0) begin failures++; $display("FAIL loss_sys_rst_n1: got %b expected 0", bus.sys_rst); end
    step(1);
    checks++;
    if (bus.sys_rst !== 1'b1) begin failures++; $display("FAIL loss_sys_rst_n2: got %b expected 1", bus.sys_rst); end
    checks++;
    if (bus.relock_cnt !== 8'd1) begin failures++; $display("FAIL loss_relock_1: got %0d expected 1", bus.relock_cnt); end
    bus.locked = 1'b1;
    wait_sig(0, 1'b1, 40, ok, at);
    all_ok = ok;
    for (int i = 0; i < 2; i++) begin loss_event(ok); all_ok &= ok; end
    checks++;
    if (!all_ok) begin failures++; $display("FAIL loss_relock_timeout: got 0 expected 1"); end
    checks++;
    if (bus.relock_cnt !== 8'd3) begin failures++; $display("FAIL loss_relock_3: got %0d expected 3", bus.relock_cnt); end
    all_ok = 1'b1;
    for (int i = 0; i < 252; i++) begin loss_event(ok); all_ok &= ok; end
    checks++;
    if (bus.relock_cnt !== 8'd255) begin failures++; $display("FAIL loss_relock_255: got %0d expected 255", bus.relock_cnt); end
    for (int i = 0; i < 45; i++) begin loss_event(ok); all_ok &= ok; end
    checks++;
    if (!all_ok) begin failures++; $display("FAIL loss_sat_timeout: got 0 expected 1"); end
    checks++;
    if (bus.relock_cnt !== 8'd255) begin failures++; $display("FAIL loss_relock_sat: got %0d expected 255", bus.relock_cnt); end
  endtask

  task automatic test_dcm_rst_override();
    bit early;
    bus.locked = 1'b0;
    step(3);
    bus.locked = 1'b1;
    step(15);
    bus.dcm_rst = 1'b1;
    step(1);
    bus.dcm_rst = 1'b0;
    checks++;
    if (bus.lock_ok !== 1'b0) begin failures++; $display("FAIL ovr_lock_ok_during: got %b expected 0", bus.lock_ok); end
    early = 1'b0;
    for (int i = 0; i < 17; i++) begin step(1); if (bus.lock_ok !== 1'b0) early = 1'b1; end
    checks++;
    if (early !== 1'b0) begin failures++; $display("FAIL ovr_no_early_release: got %b expected 0", early); end
    step(1);
    checks++;
    if (bus.lock_ok !== 1'b1) begin failures++; $display("FAIL ovr_release: got %b expected 1", bus.lock_ok); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit all_ok;
    int at;
    do_reset();
    bus.dcm_rst = 1'b0;
    bus.locked  = 1'b1;
    wait_sig(0, 1'b1, 60, ok, at);
    all_ok = ok;
    for (int i = 0; i < 5; i++) begin loss_event(ok); all_ok &= ok; end
    checks++;
    if (!all_ok || bus.relock_cnt !== 8'd5 || bus.clkin_stop !== 1'b0) begin
      failures++; $display("FAIL mid_setup: got relock=%0d stop=%b expected relock=5 stop=0", bus.relock_cnt, bus.clkin_stop);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (bus.sys_rst !== 1'b1) begin failures++; $display("FAIL mid_sys_rst: got %b expected 1", bus.sys_rst); end
    checks++;
    if (bus.lock_ok !== 1'b0) begin failures++; $display("FAIL mid_lock_ok: got %b expected 0", bus.lock_ok); end
    checks++;
    if (bus.relock_cnt !== 8'd0) begin failures++; $display("FAIL mid_relock_cnt: got %0d expected 0", bus.relock_cnt); end
    checks++;
    if (bus.clkin_stop !== 1'b0) begin failures++; $display("FAIL mid_clkin_stop: got %b expected 0", bus.clkin_stop); end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    rst         = 1'b1;
    bus.dcm_rst = 1'b1;
    bus.locked  = 1'b0;
    test_reset();
    test_normal_lock();
    test_glitch();
    test_clock_stop();
    test_lock_loss();
    test_dcm_rst_override();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
